// File: rtl/nibble_pkg.sv
// Shared types for the Nibble processor control path.
// Holds the opcode and controller state encodings plus small opcode helpers.
// Pure declarations: no latency, no flow control.
package nibble_pkg;

    localparam int OP_W = 3;

    typedef enum logic [OP_W-1:0] {
        OP_NOP  = 3'd0,
        OP_ADD  = 3'd1,
        OP_SUB  = 3'd2,
        OP_ADDM = 3'd3,
        OP_SUBM = 3'd4,
        OP_ST   = 3'd5,
        OP_JMP  = 3'd6,
        OP_HALT = 3'd7
    } op_t;

    typedef enum logic [2:0] {
        S_FETCH    = 3'd0,
        S_LOAD_IR  = 3'd1,
        S_LOAD_OPS = 3'd2,
        S_MEM_RD   = 3'd3,
        S_EXEC     = 3'd4,
        S_HALT     = 3'd5
    } ctl_state_t;

    // Opcodes whose second operand comes from RAM[addr].
    function automatic logic is_mem_op(input op_t o);
        return (o == OP_ADDM) || (o == OP_SUBM);
    endfunction

    // Opcodes that write the R register (and therefore the flags).
    function automatic logic writes_r(input op_t o);
        return (o == OP_ADD) || (o == OP_SUB) || (o == OP_ADDM) || (o == OP_SUBM);
    endfunction

endpackage

// File: rtl/nibble_control.sv
// Sequencing control unit for the Nibble processor: fetch/decode/exec FSM, status flags, retired counter.
// Latency: 4 cycles per instruction, 5 for ADDM/SUBM; strobes are Moore-decoded from state and op.
// Backpressure: ena=0 freezes state, flags and counter and forces every strobe low that cycle.
//
// Ports: clock/reset (sync, active-low), ena run enable, op latched opcode,
// alu_result/alu_ovf adder outputs for the flags; outputs are the datapath
// strobes/selects, zero_flag/ovf_flag, halted and the retired-instruction count.
module nibble_control
    import nibble_pkg::*;
#(
    parameter int CNT_W = 16
) (
    input  logic             clock,
    input  logic             reset,
    input  logic             ena,
    input  logic [OP_W-1:0]  op,
    input  logic [7:0]       alu_result,
    input  logic             alu_ovf,
    output logic             pc_en,
    output logic             pc_load,
    output logic             ir_load,
    output logic             ops_load,
    output logic             sel_comp,
    output logic             sel_mem,
    output logic             r_load,
    output logic             ram_we,
    output logic             zero_flag,
    output logic             ovf_flag,
    output logic             halted,
    output logic [CNT_W-1:0] retired
);

    localparam logic [CNT_W-1:0] CNT_ONE = {{(CNT_W-1){1'b0}}, 1'b1};

    ctl_state_t       r_state;
    ctl_state_t       w_phase;
    op_t              w_op;
    logic             r_zero;
    logic             r_ovf;
    logic [CNT_W-1:0] r_retired;

    logic w_pc_en, w_pc_load, w_ir_load, w_ops_load;
    logic w_sel_comp, w_sel_mem, w_r_load, w_ram_we;

    assign w_op = op_t'(op);

    // op only becomes valid the cycle after LOAD_OPS, so the memory-read
    // branch is resolved in the slot following LOAD_OPS: for non-memory
    // opcodes that slot behaves as EXEC directly.
    always_comb begin
        w_phase = r_state;
        if ((r_state == S_MEM_RD) && !is_mem_op(w_op)) begin
            w_phase = S_EXEC;
        end
    end

    always_comb begin
        w_pc_en    = 1'b0;
        w_pc_load  = 1'b0;
        w_ir_load  = 1'b0;
        w_ops_load = 1'b0;
        w_sel_comp = 1'b0;
        w_sel_mem  = 1'b0;
        w_r_load   = 1'b0;
        w_ram_we   = 1'b0;
        case (w_phase)
            S_LOAD_IR:  w_ir_load  = 1'b1;
            S_LOAD_OPS: w_ops_load = 1'b1;
            S_MEM_RD:   w_sel_mem  = 1'b1;
            S_EXEC: begin
                w_sel_comp = (w_op == OP_SUB) || (w_op == OP_SUBM);
                w_sel_mem  = is_mem_op(w_op);
                w_r_load   = writes_r(w_op);
                w_ram_we   = (w_op == OP_ST);
                w_pc_load  = (w_op == OP_JMP);
                w_pc_en    = (w_op != OP_JMP) && (w_op != OP_HALT);
            end
            default: ;
        endcase
    end

    // A stalled phase repeats when ena returns, so gating here loses nothing.
    assign pc_en    = ena & w_pc_en;
    assign pc_load  = ena & w_pc_load;
    assign ir_load  = ena & w_ir_load;
    assign ops_load = ena & w_ops_load;
    assign sel_comp = ena & w_sel_comp;
    assign sel_mem  = ena & w_sel_mem;
    assign r_load   = ena & w_r_load;
    assign ram_we   = ena & w_ram_we;

    always_ff @(posedge clock) begin
        if (!reset) begin
            r_state   <= S_FETCH;
            r_zero    <= 1'b0;
            r_ovf     <= 1'b0;
            r_retired <= '0;
        end else if (ena) begin
            case (w_phase)
                S_FETCH:    r_state <= S_LOAD_IR;
                S_LOAD_IR:  r_state <= S_LOAD_OPS;
                S_LOAD_OPS: r_state <= S_MEM_RD;
                S_MEM_RD:   r_state <= S_EXEC;
                S_EXEC: begin
                    r_state   <= (w_op == OP_HALT) ? S_HALT : S_FETCH;
                    r_retired <= r_retired + CNT_ONE;
                    if (w_r_load) begin
                        r_zero <= (alu_result == 8'd0);
                        r_ovf  <= alu_ovf;
                    end
                end
                S_HALT:     r_state <= S_HALT;
                default:    r_state <= S_FETCH;
            endcase
        end
    end

    assign zero_flag = r_zero;
    assign ovf_flag  = r_ovf;
    assign halted    = (r_state == S_HALT);
    assign retired   = r_retired;

endmodule

// File: doc/nibble_control.md
# nibble_control

Sequencing control unit for the Nibble processor. It steps the datapath through fetch, instruction-register load, operand-register load, optional RAM read and execute phases. From the latched 3-bit opcode it drives every load, select and write strobe: PC, instruction register, x/y/op/addr registers, complement mux, memory mux, R register and RAM write enable. It also keeps the status flags and a retired-instruction counter.

## Interface
- `CNT_W`, default 16: width of the retired-instruction counter.
- `clock`  in  1  system clock; all state changes on the rising edge.
- `reset`  in  1  synchronous, active-low; sampled on the rising edge of `clock`.
- `ena`  in  1  run enable; low freezes the FSM.
- `op`  in  3  opcode from the op register.
- `alu_result`  in  8  adder output, for the zero flag.
- `alu_ovf`  in  1  adder overflow.
- `pc_en`  out  1  PC increments at the end of this cycle.
- `pc_load`  out  1  PC loads `addr` (jump).
- `ir_load`  out  1  instruction register captures ROM `q`.
- `ops_load`  out  1  x/y/op/addr registers capture decoder outputs.
- `sel_comp`  out  1  mux1 selects two's-complement of x.
- `sel_mem`  out  1  mux2 selects RAM output instead of y.
- `r_load`  out  1  R register captures adder output.
- `ram_we`  out  1  RAM write of R to `addr`.
- `zero_flag`  out  1  last R result was 0.
- `ovf_flag`  out  1  last R result overflowed.
- `halted`  out  1  FSM is in HALT.
- `retired`  out  CNT_W  count of completed instructions, including HALT.

## Operation
- **Opcodes:**
  - 000 NOP
  - 001 ADD, R = x + y
  - 010 SUB, R = y − x
  - 011 ADDM, R = x + RAM[addr]
  - 100 SUBM, R = RAM[addr] − x
  - 101 ST, RAM[addr] = R
  - 110 JMP, PC = addr
  - 111 HALT
- **States:** FETCH → LOAD_IR → LOAD_OPS → (MEM_RD if ADDM/SUBM) → EXEC → FETCH. EXEC with HALT goes to HALT instead of FETCH.
- **FETCH:** ROM sees the stable PC; no strobes.
- **LOAD_IR:** `ir_load`=1.
- **LOAD_OPS:** `ops_load`=1.
- **MEM_RD:** `sel_mem`=1 while RAM reads `addr`; no strobes.
- **EXEC, selects:**
  - `sel_comp`=1 for SUB and SUBM.
  - `sel_mem`=1 for ADDM and SUBM.
- **EXEC, writes:**
  - `r_load`=1 for opcodes 001–100.
  - `ram_we`=1 for ST.
  - `pc_load`=1 for JMP.
- **EXEC, PC and counter:**
  - `pc_en`=1 for all opcodes except JMP and HALT.
  - `retired` increments for every opcode, including HALT.
- **Flags:** update only on cycles with `r_load`=1.
  - `zero_flag` = (`alu_result`==0).
  - `ovf_flag` = `alu_ovf`.
  - Otherwise both hold their value.
- **HALT:** absorbing state. `halted`=1, all strobes 0. Exited only by reset.
- **`ena`=0:** state, flags and counter hold; all strobes forced to 0 in that cycle. The interrupted phase re-executes when `ena` returns to 1, so no strobe is lost or doubled.
- **`retired` overflow:** wraps modulo 2^CNT_W.
- **Strobe exclusivity:** at most one of `pc_en`/`pc_load` is high in any cycle; `r_load` and `ram_we` are never high together.

## Timing
- **Reset** (`reset`=0 at a rising edge), regardless of current state, including mid-EXEC or HALT:
  - Next state is FETCH.
  - All strobes 0.
  - Flags 0, `halted`=0, `retired`=0.
- **Output type:** strobes are Moore outputs decoded from state and the registered `op`; no combinational path from `ena` to state.
- **Strobe gating:** strobes are gated by `ena` combinationally.
- **Latency per instruction with `ena` held high:**
  - NOP/ADD/SUB/ST/JMP: 4 cycles.
  - ADDM/SUBM: 5 cycles.
  - HALT: 4 cycles to enter HALT.
- **Data-to-FSM timing:** `op` is valid from the cycle after LOAD_OPS. `alu_result`/`alu_ovf` are sampled on the same edge as `r_load`.

## Structure
- `nibble_pkg` holds:
  - opcode enum `op_t` (OP_NOP … OP_HALT);
  - state enum `ctl_state_t`;
  - constant `OP_W` = 3.
- Single module; the flag register and counter stay inline. No sub-module is warranted.

## Test plan
- **Reset mid-EXEC:** `reset`=0 for 1 cycle during EXEC of ADD → next cycle state FETCH, all strobes 0, `retired`=0, flags 0.
- **ADD:** `op`=001, `alu_result`=0x00, `alu_ovf`=1 →
  - `ir_load`, `ops_load`, then `r_load`+`pc_en` on cycles 2, 3, 4 after FETCH;
  - `zero_flag`=1, `ovf_flag`=1;
  - `retired`=1.
- **SUBM:** `op`=100 →
  - MEM_RD present;
  - EXEC has `sel_comp`=1, `sel_mem`=1, `r_load`=1;
  - total 5 cycles.
- **ST then JMP:**
  - ST: `ram_we`=1 with `pc_en`=1, `r_load`=0, flags unchanged.
  - JMP: `pc_load`=1, `pc_en`=0.
- **Stall:** `ena`=0 for 3 cycles in LOAD_IR → no strobes, state held; `ir_load` asserted exactly once after `ena` returns to 1.
- **HALT and counter wrap:** `op`=111 → `halted`=1 forever, strobes 0, `retired` incremented once. With CNT_W=4, 16 NOPs → `retired` wraps to 0.
